// File: rtl/fifo_read_sequencer.sv
// Command-driven read/reset sequencer for the SPI receive FIFO.
// Optional empty-wait timeout is built only when FIFO_SEQ_TIMEOUT_EN is defined.
module fifo_read_sequencer #(
  parameter int GAP_CYCLES     = 2,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        wclk,
  input  logic        empty,
  input  logic        fullflag,
  output logic        fifo_rclk,
  output logic        fifo_rst,
  output logic        fullflag_alarm,
  output logic        busy,
  output logic        done,
  output logic [8:0]  rd_count,
  output logic        timeout_err,
  output logic [2:0]  state_dbg
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_GAP   = 3'd2,
    S_WAIT  = 3'd3,
    S_RESET = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_next;

  logic [8:0]       len_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [RST_W-1:0] rst_cnt;

  logic cmd_reset, cmd_burst, cmd_clr;
  logic rd_last, gap_last, rst_last, read_fire;
  logic wait_expire;

  logic       fifo_rclk_d, fifo_rst_d, alarm_d, busy_d, done_d, timeout_d;
  logic [8:0] rd_count_d;

  // RESET outranks BURST in the same word; BURST only starts from IDLE.
  assign cmd_reset = wclk & din[16];
  assign cmd_burst = wclk & din[31] & ~din[16] & (state == S_IDLE);
  assign cmd_clr   = wclk & din[17];

  assign rd_last   = ((rd_count + 9'd1) == len_q);
  assign gap_last  = (int'(gap_cnt) == GAP_CYCLES - 1);
  assign rst_last  = (int'(rst_cnt) == RST_CYCLES - 1);
  assign read_fire = (state == S_READ) & ~empty & ~cmd_reset;

`ifdef FIFO_SEQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] wait_cnt;

  assign wait_expire = (state == S_WAIT) & empty & (int'(wait_cnt) == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if ((state == S_WAIT) && empty && !wait_expire) begin
      wait_cnt <= wait_cnt + TO_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign wait_expire = 1'b0;
`endif

  logic unused_din;
  assign unused_din = ^{din[30:18], din[15:8], TIMEOUT_CYCLES[0]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (cmd_reset) begin
      state_next = S_RESET;
    end else begin
      case (state)
        S_IDLE:  if (cmd_burst) state_next = S_READ;
        S_READ: begin
          if (empty)               state_next = S_WAIT;
          else if (rd_last)        state_next = S_DONE;
          else if (GAP_CYCLES > 0) state_next = S_GAP;
          else                     state_next = S_READ;
        end
        S_GAP:   if (gap_last) state_next = S_READ;
        S_WAIT: begin
          if (!empty)           state_next = S_READ;
          else if (wait_expire) state_next = S_DONE;
        end
        S_RESET: if (rst_last) state_next = S_DONE;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Output logic; every output is registered below
  always_comb begin
    fifo_rclk_d = read_fire;
    fifo_rst_d  = (state == S_RESET);
    done_d      = (state == S_DONE);
    busy_d      = (state_next != S_IDLE);

    rd_count_d = rd_count;
    if (cmd_burst)      rd_count_d = 9'd0;
    else if (read_fire) rd_count_d = rd_count + 9'd1;

    // Alarm is forced clear on RESET entry and throughout RESET; otherwise set beats clear.
    alarm_d = fullflag_alarm;
    if (cmd_reset || (state == S_RESET)) alarm_d = 1'b0;
    else if (fullflag)                   alarm_d = 1'b1;
    else if (cmd_clr)                    alarm_d = 1'b0;

    timeout_d = timeout_err;
    if (cmd_reset || cmd_burst) timeout_d = 1'b0;
    else if (wait_expire)       timeout_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_rclk      <= 1'b0;
      fifo_rst       <= 1'b0;
      fullflag_alarm <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      rd_count       <= 9'd0;
      timeout_err    <= 1'b0;
    end else begin
      fifo_rclk      <= fifo_rclk_d;
      fifo_rst       <= fifo_rst_d;
      fullflag_alarm <= alarm_d;
      busy           <= busy_d;
      done           <= done_d;
      rd_count       <= rd_count_d;
      timeout_err    <= timeout_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q   <= 9'd0;
      gap_cnt <= '0;
      rst_cnt <= '0;
    end else begin
      if (cmd_burst) len_q <= (din[7:0] == 8'd0) ? 9'd256 : {1'b0, din[7:0]};
      if ((state == S_GAP) && !gap_last && !cmd_reset) gap_cnt <= gap_cnt + GAP_W'(1);
      else                                              gap_cnt <= '0;
      if ((state == S_RESET) && !rst_last && !cmd_reset) rst_cnt <= rst_cnt + RST_W'(1);
      else                                               rst_cnt <= '0;
    end
  end

  assign state_dbg = state;

endmodule
